console_io: RTL and testbench



---
 rtl/console_io_pkg.sv | 29 ++
 rtl/console_rx_fifo.sv | 84 ++++++++
 rtl/console_io.sv | 177 +++++++++++++++++
 tb/tb_console_io.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/console_io_pkg.sv
// Shared constants and state encodings for the LC-3 console I/O block.
package console_io_pkg;

    localparam logic [15:0] KBSR_ADDR  = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR  = 16'hFE02;
    localparam logic [15:0] DSR_ADDR   = 16'hFE04;
    localparam logic [15:0] DDR_ADDR   = 16'hFE06;

    localparam logic [15:0] READY_WORD = 16'h8000;
    localparam logic [15:0] CLEAR_WORD = 16'h0000;

    typedef enum logic [0:0] {
        K_EMPTY = 1'b0,
        K_FULL  = 1'b1
    } kb_state_t;

    typedef enum logic [1:0] {
        D_INIT    = 2'd0,
        D_IDLE    = 2'd1,
        D_CAPTURE = 2'd2,
        D_SEND    = 2'd3
    } disp_state_t;

    // Zero-extend a received byte into a KBDR word.
    function automatic logic [15:0] zext_byte(input logic [7:0] b);
        return {8'h00, b};
    endfunction

endpackage

// File: rtl/console_rx_fifo.sv
// Synchronous byte FIFO with registered full/empty flags; read data is the
// head entry, so a freshly pushed byte is visible only after the push edge.
module console_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       empty_o,
    output logic       full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push_s, pop_s;

    // Full blocks pushes even when the same cycle pops.
    assign push_s  = push_i & ~full_q;
    assign pop_s   = pop_i & ~empty_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = empty_q;
    assign full_o  = full_q;

    // Pointer, occupancy and flag next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    // Control state registers; reset flushes the FIFO.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are don't-care once the pointers say empty.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/console_io.sv
// LC-3 console bridge: byte streams in/out mapped onto KBSR/KBDR and DSR/DDR
// load strobes for DATAPATH.
module console_io
    import console_io_pkg::*;
#(
    parameter int RX_DEPTH = 4
) (
    input  logic        i_Clk,
    input  logic        reset_,
    input  logic [15:0] mar,
    input  logic        MIO_EN,
    input  logic        RW,
    input  logic [15:0] ddr,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [15:0] kbdr_ext,
    output logic [15:0] kbsr_ext,
    output logic [15:0] dsr_ext,
    output logic        LD_KBDR_EXT,
    output logic        LD_KBSR_EXT,
    output logic        LD_DSR_EXT
);

    logic        kbdr_cond_s, kbdr_cond_q, kbdr_rd_s;
    logic        ddr_cond_s, ddr_cond_q, ddr_wr_s;
    logic        fifo_push_s, fifo_pop_s, fifo_empty_s, fifo_full_s;
    logic [7:0]  fifo_rdata_s;

    kb_state_t   kb_state_q, kb_state_d;
    disp_state_t disp_state_q, disp_state_d;
    logic [15:0] kbdr_q, kbdr_d, kbsr_q, kbsr_d, dsr_q, dsr_d;
    logic        ld_kbdr_q, ld_kbdr_d, ld_kbsr_q, ld_kbsr_d, ld_dsr_q, ld_dsr_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;

    // Accesses can be held for several cycles; act only on the first one.
    assign kbdr_cond_s = MIO_EN & ~RW & (mar == KBDR_ADDR);
    assign ddr_cond_s  = MIO_EN &  RW & (mar == DDR_ADDR);
    assign kbdr_rd_s   = kbdr_cond_s & ~kbdr_cond_q;
    assign ddr_wr_s    = ddr_cond_s  & ~ddr_cond_q;

    assign rx_ready    = ~fifo_full_s;
    assign fifo_push_s = rx_valid & ~fifo_full_s;

    console_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i   (i_Clk),
        .rst_n_i (reset_),
        .push_i  (fifo_push_s),
        .wdata_i (rx_data),
        .pop_i   (fifo_pop_s),
        .rdata_o (fifo_rdata_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s)
    );

    // Keyboard FSM: KBDR is reloaded only after software has read it.
    always_comb begin
        kb_state_d = kb_state_q;
        kbdr_d     = kbdr_q;
        kbsr_d     = kbsr_q;
        ld_kbdr_d  = 1'b0;
        ld_kbsr_d  = 1'b0;
        fifo_pop_s = 1'b0;
        case (kb_state_q)
            K_EMPTY: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    kbdr_d     = zext_byte(fifo_rdata_s);
                    kbsr_d     = READY_WORD;
                    ld_kbdr_d  = 1'b1;
                    ld_kbsr_d  = 1'b1;
                    kb_state_d = K_FULL;
                end else begin
                    kb_state_d = K_EMPTY;
                end
            end
            K_FULL: begin
                if (kbdr_rd_s) begin
                    kbsr_d     = CLEAR_WORD;
                    ld_kbsr_d  = 1'b1;
                    kb_state_d = K_EMPTY;
                end else begin
                    kb_state_d = K_FULL;
                end
            end
            default: kb_state_d = K_EMPTY;
        endcase
    end

    // Display FSM: DDR writes outside D_IDLE are dropped.
    always_comb begin
        disp_state_d = disp_state_q;
        dsr_d        = dsr_q;
        ld_dsr_d     = 1'b0;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        case (disp_state_q)
            D_INIT: begin
                dsr_d        = READY_WORD;
                ld_dsr_d     = 1'b1;
                disp_state_d = D_IDLE;
            end
            D_IDLE: begin
                if (ddr_wr_s) begin
                    dsr_d        = CLEAR_WORD;
                    ld_dsr_d     = 1'b1;
                    disp_state_d = D_CAPTURE;
                end else begin
                    disp_state_d = D_IDLE;
                end
            end
            D_CAPTURE: begin
                tx_data_d    = ddr[7:0];
                tx_valid_d   = 1'b1;
                disp_state_d = D_SEND;
            end
            D_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    tx_valid_d   = 1'b0;
                    dsr_d        = READY_WORD;
                    ld_dsr_d     = 1'b1;
                    disp_state_d = D_IDLE;
                end else begin
                    disp_state_d = D_SEND;
                end
            end
            default: disp_state_d = D_INIT;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_Clk or negedge reset_) begin
        if (!reset_) begin
            kbdr_cond_q  <= 1'b0;
            ddr_cond_q   <= 1'b0;
            kb_state_q   <= K_EMPTY;
            disp_state_q <= D_INIT;
            kbdr_q       <= 16'h0000;
            kbsr_q       <= 16'h0000;
            dsr_q        <= 16'h0000;
            ld_kbdr_q    <= 1'b0;
            ld_kbsr_q    <= 1'b0;
            ld_dsr_q     <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
        end else begin
            kbdr_cond_q  <= kbdr_cond_s;
            ddr_cond_q   <= ddr_cond_s;
            kb_state_q   <= kb_state_d;
            disp_state_q <= disp_state_d;
            kbdr_q       <= kbdr_d;
            kbsr_q       <= kbsr_d;
            dsr_q        <= dsr_d;
            ld_kbdr_q    <= ld_kbdr_d;
            ld_kbsr_q    <= ld_kbsr_d;
            ld_dsr_q     <= ld_dsr_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
        end
    end

    assign kbdr_ext    = kbdr_q;
    assign kbsr_ext    = kbsr_q;
    assign dsr_ext     = dsr_q;
    assign LD_KBDR_EXT = ld_kbdr_q;
    assign LD_KBSR_EXT = ld_kbsr_q;
    assign LD_DSR_EXT  = ld_dsr_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_console_io.sv
// Directed bench for console_io: reset/DSR init, keyboard path, FIFO
// back-pressure, display path and mid-transfer reset.
module tb_console_io;

    logic        i_Clk = 1'b0;
    logic        reset_ = 1'b0;
    logic [15:0] mar = 16'h0000;
    logic        MIO_EN = 1'b0;
    logic        RW = 1'b0;
    logic [15:0] ddr = 16'h0000;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic [15:0] kbdr_ext, kbsr_ext, dsr_ext;
    logic        LD_KBDR_EXT, LD_KBSR_EXT, LD_DSR_EXT;

    int total = 0;
    int bad   = 0;

    // Strobe/handshake tallies, sampled mid-cycle.
    int          n_kbdr = 0, n_kbsr = 0, n_dsr = 0, n_tx = 0;
    logic [15:0] last_kbsr = 16'h0000;
    logic [15:0] last_dsr  = 16'h0000;

    console_io #(.RX_DEPTH(4)) dut (
        .i_Clk       (i_Clk),
        .reset_      (reset_),
        .mar         (mar),
        .MIO_EN      (MIO_EN),
        .RW          (RW),
        .ddr         (ddr),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .kbdr_ext    (kbdr_ext),
        .kbsr_ext    (kbsr_ext),
        .dsr_ext     (dsr_ext),
        .LD_KBDR_EXT (LD_KBDR_EXT),
        .LD_KBSR_EXT (LD_KBSR_EXT),
        .LD_DSR_EXT  (LD_DSR_EXT)
    );

    always #5 i_Clk = ~i_Clk;

    always @(negedge i_Clk) begin
        if (LD_KBDR_EXT) n_kbdr++;
        if (LD_KBSR_EXT) begin
            n_kbsr++;
            last_kbsr = kbsr_ext;
        end
        if (LD_DSR_EXT) begin
            n_dsr++;
            last_dsr = dsr_ext;
        end
        if (tx_valid && tx_ready) n_tx++;
    end

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_kbdr(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (LD_KBDR_EXT) seen = 1'b1;
        end
    endtask

    task automatic kbdr_read_pulse();
        MIO_EN = 1'b1; RW = 1'b0; mar = 16'hFE02;
        tick();
        MIO_EN = 1'b0; mar = 16'h0000;
    endtask

    task automatic ddr_write_pulse(input logic [15:0] val);
        ddr = val; MIO_EN = 1'b1; RW = 1'b1; mar = 16'hFE06;
        tick();
        MIO_EN = 1'b0; RW = 1'b0; mar = 16'h0000;
    endtask

    initial begin
        logic        seen;
        int          s_kbsr, s_kbdr, s_dsr, s_tx;
        logic [7:0]  exp_b;

        // ---- 1: reset and DSR init ----
        tick(); tick();
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_strobes", {29'd0, LD_KBDR_EXT, LD_KBSR_EXT, LD_DSR_EXT}, 32'd0);
        check("rst_kbsr", {16'd0, kbsr_ext}, 32'd0);
        reset_ = 1'b1;
        tick();
        check("init_ld_dsr", {31'd0, LD_DSR_EXT}, 32'd1);
        check("init_dsr_val", {16'd0, dsr_ext}, 32'h8000);
        tick();
        check("init_ld_dsr_single", {31'd0, LD_DSR_EXT}, 32'd0);
        tick(); tick();
        check("init_dsr_count", n_dsr, 32'd1);
        check("init_no_kb_strobe", n_kbdr + n_kbsr, 32'd0);
        check("init_rx_ready", {31'd0, rx_ready}, 32'd1);

        // ---- 2: single byte and held read ----
        rx_valid = 1'b1; rx_data = 8'h41;
        tick();
        rx_valid = 1'b0;
        wait_kbdr(3, seen);
        check("kb41_seen", {31'd0, seen}, 32'd1);
        check("kb41_kbdr", {16'd0, kbdr_ext}, 32'h0041);
        check("kb41_ld_kbsr", {31'd0, LD_KBSR_EXT}, 32'd1);
        check("kb41_kbsr", {16'd0, kbsr_ext}, 32'h8000);
        tick();
        s_kbsr = n_kbsr;
        MIO_EN = 1'b1; RW = 1'b0; mar = 16'hFE02;
        for (int i = 0; i < 4; i++) tick();
        MIO_EN = 1'b0; mar = 16'h0000;
        tick(); tick();
        check("held_rd_one_strobe", n_kbsr - s_kbsr, 32'd1);
        check("held_rd_kbsr_clear", {16'd0, last_kbsr}, 32'h0000);

        // ---- 3: burst of five bytes into a depth-4 FIFO ----
        s_kbdr = n_kbdr;
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1; rx_data = 8'h61 + 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        check("burst_full_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("burst_kbdr_61", {16'd0, kbdr_ext}, 32'h0061);
        check("burst_one_load", n_kbdr - s_kbdr, 32'd1);
        // Offered while full: must be refused.
        rx_valid = 1'b1; rx_data = 8'h70;
        tick();
        rx_valid = 1'b0;
        check("full_still_blocked", {31'd0, rx_ready}, 32'd0);
        for (int r = 0; r < 3; r++) begin
            exp_b = 8'h62 + 8'(r);
            kbdr_read_pulse();
            wait_kbdr(4, seen);
            check("seq_seen", {31'd0, seen}, 32'd1);
            check("seq_kbdr", {16'd0, kbdr_ext}, {24'd0, exp_b});
            if (r == 0) check("seq_rx_ready_back", {31'd0, rx_ready}, 32'd1);
        end
        tick(); tick();
        check("seq_no_overwrite", n_kbdr - s_kbdr, 32'd4);

        // ---- 4/5: display write, stall, stray second write, handshake ----
        s_dsr = n_dsr; s_tx = n_tx;
        tx_ready = 1'b0;
        ddr_write_pulse(16'h0048);
        check("ddr_dsr_clear_ld", {31'd0, LD_DSR_EXT}, 32'd1);
        check("ddr_dsr_clear_val", {16'd0, dsr_ext}, 32'h0000);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("send_valid", {31'd0, tx_valid}, 32'd1);
            check("send_data", {24'd0, tx_data}, 32'h48);
            tick();
        end
        ddr_write_pulse(16'h0049);
        tick(); tick();
        check("stray_data_held", {24'd0, tx_data}, 32'h48);
        check("stray_no_dsr", n_dsr - s_dsr, 32'd1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("hs_ld_dsr", {31'd0, LD_DSR_EXT}, 32'd1);
        check("hs_dsr_ready", {16'd0, dsr_ext}, 32'h8000);
        check("hs_valid_drop", {31'd0, tx_valid}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("hs_one_byte", n_tx - s_tx, 32'd1);
        check("hs_dsr_total", n_dsr - s_dsr, 32'd2);
        check("hs_idle_valid", {31'd0, tx_valid}, 32'd0);

        // ---- 6: reset during D_SEND with two FIFO entries ----
        rx_valid = 1'b1; rx_data = 8'h66;
        tick();
        rx_valid = 1'b0;
        ddr_write_pulse(16'h0052);
        tick(); tick();
        check("pre_rst_valid", {31'd0, tx_valid}, 32'd1);
        check("pre_rst_data", {24'd0, tx_data}, 32'h52);
        reset_ = 1'b0;
        #1;
        check("rst_async_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_async_rx_ready", {31'd0, rx_ready}, 32'd1);
        tick(); tick();
        s_dsr = n_dsr; s_kbdr = n_kbdr; s_tx = n_tx;
        reset_ = 1'b1;
        tick();
        check("reinit_ld_dsr", {31'd0, LD_DSR_EXT}, 32'd1);
        check("reinit_dsr_val", {16'd0, dsr_ext}, 32'h8000);
        for (int i = 0; i < 5; i++) tick();
        check("reinit_dsr_once", n_dsr - s_dsr, 32'd1);
        check("reinit_no_stale_kb", n_kbdr - s_kbdr, 32'd0);
        check("reinit_no_tx", n_tx - s_tx, 32'd0);
        check("reinit_tx_valid", {31'd0, tx_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
